// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential ALU behind req/rsp valid-ready handshakes, with iterative or barrel shifts.
// Define ALU_EXEC_BARREL_EN to build the single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic             rsp_z,
    output logic             rsp_err
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b0110;
    localparam logic [3:0] OP_LT  = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;

    // EXEC is the single cycle in which the registered result is formed.
    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic             armed;
    logic             accept;
    logic [WIDTH-1:0] a_r, b_r;
    logic [3:0]       op_r;
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] res;
    logic             res_c, res_err;

    assign accept = req_valid && req_ready;
    assign sum    = {1'b0, a_r} + {1'b0, b_r};
    assign dif    = {1'b0, a_r} - {1'b0, b_r};

`ifdef ALU_EXEC_BARREL_EN
    logic [SHW:0]       amt;
    logic [2*WIDTH-1:0] shl_t, shr_t;
    assign amt   = {1'b0, b_r[SHW-1:0]} + (SHW+1)'(1);
    assign shl_t = {{WIDTH{1'b0}}, a_r} << amt;
    assign shr_t = {a_r, {WIDTH{1'b0}}} >> amt;
`else
    logic         c_r;
    logic [SHW:0] cnt;
    logic         req_shift;
    assign req_shift = (req_op == OP_SHL) || (req_op == OP_SHR);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
`ifdef ALU_EXEC_BARREL_EN
            IDLE:    state_nx = accept ? EXEC : IDLE;
`else
            IDLE:    state_nx = accept ? (req_shift ? SHIFT : EXEC) : IDLE;
            SHIFT:   state_nx = (cnt == (SHW+1)'(1)) ? EXEC : SHIFT;
`endif
            EXEC:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && armed && (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_err = 1'b0;
        case (op_r)
            OP_ADD:  {res_c, res} = sum;
            OP_SUB:  {res_c, res} = dif;
            OP_NOR:  res = ~(a_r | b_r);
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, a_r == b_r};
            OP_LT:   res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
`ifdef ALU_EXEC_BARREL_EN
            OP_SHL:  {res_c, res} = {shl_t[WIDTH], shl_t[WIDTH-1:0]};
            OP_SHR:  {res_c, res} = {shr_t[WIDTH-1], shr_t[2*WIDTH-1:WIDTH]};
`else
            OP_SHL, OP_SHR: {res_c, res} = {c_r, a_r};
`endif
            default: res_err = 1'b1;
        endcase
    end

    // a_r doubles as the shift register in the iterative build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            rsp_out   <= '0;
            rsp_carry <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_err   <= 1'b0;
`ifndef ALU_EXEC_BARREL_EN
            c_r       <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
            if (accept) begin
                a_r  <= req_a;
                b_r  <= req_b;
                op_r <= req_op;
`ifndef ALU_EXEC_BARREL_EN
                c_r  <= 1'b0;
                cnt  <= {1'b0, req_b[SHW-1:0]} + (SHW+1)'(1);
            end else if (state == SHIFT) begin
                c_r  <= (op_r == OP_SHL) ? a_r[WIDTH-1] : a_r[0];
                a_r  <= (op_r == OP_SHL) ? (a_r << 1) : (a_r >> 1);
                cnt  <= cnt - (SHW+1)'(1);
`endif
            end
            if (state == EXEC) begin
                rsp_out   <= res;
                rsp_carry <= res_c;
                rsp_z     <= (res == '0);
                rsp_err   <= res_err;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a queue scoreboard checked by an independent response monitor.
module tb_alu_exec_unit;
    typedef struct {
        string      name;
        logic [7:0] out;
        logic       c;
        logic       err;
        int         lat;
        int         acc;
        bit         seen;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1;
    logic       req_ready, rsp_valid, rsp_carry, rsp_z, rsp_err;
    logic [7:0] req_a = '0, req_b = '0, rsp_out;
    logic [3:0] req_op = '0;
    int         tests = 0, fails = 0, cyc = 0, last_acc = 0, rel = 0;
    exp_t       exp_q[$];
    exp_t       m;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
        .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op, input logic [7:0] b);
`ifdef ALU_EXEC_BARREL_EN
        return 1;
`else
        return (op == 4'b1011 || op == 4'b1100) ? 2 + int'(b[2:0]) : 1;
`endif
    endfunction

    // Response fields are compared as {out, carry, z, err}; every visible cycle is checked, so held responses must stay stable.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got out=0x%0h with no request outstanding", rsp_out);
            end else begin
                m = exp_q[0];
                check(m.name, {rsp_out, rsp_carry, rsp_z, rsp_err}, {m.out, m.c, m.out == 8'd0, m.err});
                if (!m.seen) begin
                    check({m.name, "_lat"}, cyc - m.acc, m.lat);
                    exp_q[0].seen = 1'b1;
                end
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] out, input logic c, input logic err);
        exp_t e;
        int   k;
        req_a = a;
        req_b = b;
        req_op = op;
        req_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 100);
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: req_ready=0 after %0d cycles, expected 1", name, k);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_acc = cyc;
        e = '{name: name, out: out, c: c, err: err, lat: lat_of(op, b), acc: cyc, seen: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp", {rsp_valid, rsp_out, rsp_carry, rsp_z, rsp_err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rel_req_ready", req_ready, 1);

        issue("add_15_10", 8'd15, 8'd10, 4'b0001, 8'd25, 1'b0, 1'b0);
        issue("add_200_100", 8'd200, 8'd100, 4'b0001, 8'd44, 1'b1, 1'b0);
        issue("sub_20_25", 8'd20, 8'd25, 4'b0010, 8'd251, 1'b1, 1'b0);
        issue("sub_25_20", 8'd25, 8'd20, 4'b0010, 8'd5, 1'b0, 1'b0);
        issue("eq_30_30", 8'd30, 8'd30, 4'b0110, 8'd1, 1'b0, 1'b0);
        issue("eq_3_4", 8'd3, 8'd4, 4'b0110, 8'd0, 1'b0, 1'b0);
        issue("lt_10_20", 8'd10, 8'd20, 4'b1000, 8'd1, 1'b0, 1'b0);
        issue("lt_20_10", 8'd20, 8'd10, 4'b1000, 8'd0, 1'b0, 1'b0);
        issue("add_0_0", 8'd0, 8'd0, 4'b0001, 8'd0, 1'b0, 1'b0);
        issue("shl_0f_b0", 8'h0F, 8'd0, 4'b1011, 8'h1E, 1'b0, 1'b0);
        issue("shr_f0_b3", 8'hF0, 8'd3, 4'b1100, 8'h0F, 1'b0, 1'b0);
        issue("shl_81_b7", 8'h81, 8'd7, 4'b1011, 8'h00, 1'b1, 1'b0);
        issue("shr_81_b7", 8'h81, 8'd7, 4'b1100, 8'h00, 1'b1, 1'b0);
        issue("shr_b6_b1", 8'hB6, 8'd1, 4'b1100, 8'h2D, 1'b1, 1'b0);
        issue("illegal_f", 8'd5, 8'd5, 4'b1111, 8'd0, 1'b0, 1'b1);
        drain();

        rsp_ready = 1'b0;
        issue("nor_aa_55", 8'hAA, 8'h55, 4'b0011, 8'h00, 1'b0, 1'b0);
        fork
            issue("held_sub", 8'd50, 8'd20, 4'b0010, 8'd30, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 rsp_ready = 1'b1;
                rel = cyc;
            end
        join
        check("held_accept_cycle", last_acc, rel + 2);
        drain();

        issue("rst_shr", 8'hF0, 8'd7, 4'b1100, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midshift_rst_ready", req_ready, 0);
        check("midshift_rst_rsp", {rsp_valid, rsp_out, rsp_carry, rsp_z, rsp_err}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel2_before_edge_ready", req_ready, 0);
        @(posedge clk);
        #1 check("rel2_req_ready", req_ready, 1);
        issue("post_rst_add", 8'd1, 8'd2, 4'b0001, 8'd3, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
